// File: rtl/mfm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mfm_pkg
//  Description : Shared constants and types for the MFM controller-side
//                receive logic (index monitor, read-data path).
//                CLK_HZ        - system clock frequency
//                INDEX_LOW_CYC - nominal index pulse low width in clk50 cycles
//                REV_CYC       - nominal fall-to-fall revolution period
//  Revision    : 1.0  initial release
// ============================================================================
package mfm_pkg;

    localparam int CLK_HZ        = 50_000_000;
    localparam int INDEX_LOW_CYC = 10_000;
    localparam int REV_CYC       = 833_335;

    // Index monitor states: IDLE waits for a clean high level after reset,
    // ARMED has no period reference yet, LOW/HIGH track the pulse phases.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_LOW   = 2'd2,
        ST_HIGH  = 2'd3
    } index_mon_state_t;

endpackage : mfm_pkg
`default_nettype wire

// File: rtl/mfm_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : mfm_sync_edge
//  Description : Two-flop synchronizer for an asynchronous level plus edge
//                detection against the previous synchronized value.
//  Ports       : clk      - sampling clock
//                rst      - synchronous active-high reset
//                i_async  - asynchronous input level
//                o_level  - synchronized level
//                o_valid  - high once the synchronizer holds post-reset data
//                o_rise   - synchronized level went 0 -> 1 this cycle
//                o_fall   - synchronized level went 1 -> 0 this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module mfm_sync_edge #(
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_valid,
    output logic o_rise,
    output logic o_fall
);

    logic       r_meta;
    logic       r_sync;
    logic       r_prev;
    logic [1:0] r_prime;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= RESET_LEVEL;
            r_sync  <= RESET_LEVEL;
            r_prev  <= RESET_LEVEL;
            r_prime <= 2'b00;
        end else begin
            r_meta  <= i_async;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_prime <= {r_prime[0], 1'b1};
        end
    end

    // The sync flops hold RESET_LEVEL rather than the pin for two cycles
    // after reset; o_valid tells the consumer when r_sync is trustworthy.
    assign o_level = r_sync;
    assign o_valid = r_prime[1];

    // Edges are decoded from registered state only, so the consumer's own
    // output register completes the edge-to-strobe pipeline.
    assign o_rise  =  r_sync & ~r_prev;
    assign o_fall  = ~r_sync &  r_prev;

endmodule : mfm_sync_edge
`default_nettype wire

// File: rtl/mfm_index_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : mfm_index_monitor
//  Description : Receiver for the drive's active-low index line. Measures
//                pulse width and revolution period, flags out-of-range
//                timing, detects loss of index and reports rotation lock.
//  Ports       : clk50       - 50 MHz system clock
//                reset       - synchronous active-high reset
//                index_l_in  - asynchronous active-low index input
//                index_stb   - one-cycle pulse per detected falling edge
//                width_stb   - one-cycle pulse when width updates (rise)
//                period_stb  - one-cycle pulse when period updates
//                width       - last measured low width (cycles)
//                period      - last measured fall-to-fall period (cycles)
//                width_err   - one-cycle pulse, width out of range / stuck
//                period_err  - one-cycle pulse, period out of range
//                locked      - rotation stable
//                timeout     - no index within PERIOD_MAX cycles
//                led         - active-low lock indicator
//  Revision    : 1.0  initial release
// ============================================================================
module mfm_index_monitor
    import mfm_pkg::*;
#(
    parameter int PULSE_MIN  = 5_000,
    parameter int PULSE_MAX  = 20_000,
    parameter int PERIOD_MIN = 800_000,
    parameter int PERIOD_MAX = 870_000,
    parameter int LOCK_COUNT = 3,
    parameter int CNT_W      = 24
) (
    input  logic             clk50,
    input  logic             reset,
    input  logic             index_l_in,
    output logic             index_stb,
    output logic             width_stb,
    output logic             period_stb,
    output logic [CNT_W-1:0] width,
    output logic [CNT_W-1:0] period,
    output logic             width_err,
    output logic             period_err,
    output logic             locked,
    output logic             timeout,
    output logic             led
);

    localparam int                c_GOOD_W     = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]  c_pulse_min  = CNT_W'(PULSE_MIN);
    localparam logic [CNT_W-1:0]  c_pulse_max  = CNT_W'(PULSE_MAX);
    localparam logic [CNT_W-1:0]  c_stuck_at   = CNT_W'(PULSE_MAX + 1);
    localparam logic [CNT_W-1:0]  c_period_min = CNT_W'(PERIOD_MIN);
    localparam logic [CNT_W-1:0]  c_period_max = CNT_W'(PERIOD_MAX);
    localparam logic [CNT_W-1:0]  c_tmo_at     = CNT_W'(PERIOD_MAX + 1);
    localparam logic [CNT_W-1:0]  c_cnt_ones   = '1;
    localparam logic [c_GOOD_W-1:0] c_lock     = c_GOOD_W'(LOCK_COUNT);

    logic w_level;
    logic w_valid;
    logic w_rise;
    logic w_fall;

    mfm_sync_edge #(
        .RESET_LEVEL (1'b1)
    ) u_sync (
        .clk     (clk50),
        .rst     (reset),
        .i_async (index_l_in),
        .o_level (w_level),
        .o_valid (w_valid),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    index_mon_state_t    r_state;
    logic [CNT_W-1:0]    r_width_cnt;
    logic [CNT_W-1:0]    r_period_cnt;
    logic                r_have_ref;
    logic                r_width_ok;
    logic [c_GOOD_W-1:0] r_good_cnt;

    logic                r_index_stb;
    logic                r_width_stb;
    logic                r_period_stb;
    logic [CNT_W-1:0]    r_width;
    logic [CNT_W-1:0]    r_period;
    logic                r_width_err;
    logic                r_period_err;
    logic                r_locked;
    logic                r_timeout;
    logic                r_led;

    logic w_width_ok;
    logic w_period_ok;
    logic w_tmo_evt;

    always_comb begin
        w_width_ok  = (r_width_cnt >= c_pulse_min) && (r_width_cnt <= c_pulse_max);
        w_period_ok = (r_period_cnt >= c_period_min) && (r_period_cnt <= c_period_max);
        // A fall in HIGH takes priority over an expiring period counter.
        w_tmo_evt   = (r_period_cnt == c_tmo_at) &&
                      ((r_state == ST_LOW) || ((r_state == ST_HIGH) && !w_fall));
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_width_cnt  <= '0;
            r_period_cnt <= '0;
            r_have_ref   <= 1'b0;
            r_width_ok   <= 1'b0;
            r_good_cnt   <= '0;
            r_index_stb  <= 1'b0;
            r_width_stb  <= 1'b0;
            r_period_stb <= 1'b0;
            r_width      <= '0;
            r_period     <= '0;
            r_width_err  <= 1'b0;
            r_period_err <= 1'b0;
            r_locked     <= 1'b0;
            r_timeout    <= 1'b0;
            r_led        <= 1'b1;
        end else begin
            r_index_stb  <= 1'b0;
            r_width_stb  <= 1'b0;
            r_period_stb <= 1'b0;
            r_width_err  <= 1'b0;
            r_period_err <= 1'b0;

            // Both counters restart at 1 on every fall so that the value
            // sampled at the next edge equals the cycle distance.
            if (w_fall) begin
                r_width_cnt  <= CNT_W'(1);
                r_period_cnt <= CNT_W'(1);
            end else begin
                if (r_width_cnt != c_cnt_ones) begin
                    r_width_cnt <= r_width_cnt + 1'b1;
                end
                if (r_period_cnt != c_cnt_ones) begin
                    r_period_cnt <= r_period_cnt + 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    // Only a post-reset high level arms the monitor, so a
                    // pulse already in progress is never measured.
                    if (w_valid && w_level) begin
                        r_state <= ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    if (w_fall) begin
                        r_index_stb <= 1'b1;
                        r_timeout   <= 1'b0;
                        r_have_ref  <= 1'b1;
                        r_state     <= ST_LOW;
                    end
                end

                ST_LOW: begin
                    if (w_rise) begin
                        r_width     <= r_width_cnt;
                        r_width_stb <= 1'b1;
                        r_width_err <= !w_width_ok;
                        r_width_ok  <= w_width_ok;
                        if (!w_width_ok) begin
                            r_good_cnt <= '0;
                        end
                        r_state     <= ST_HIGH;
                    end else if (r_width_cnt == c_stuck_at) begin
                        r_width_err <= 1'b1;
                        r_good_cnt  <= '0;
                    end
                    // Timeout while low drops the reference; the pulse is
                    // still followed to its rise.
                    if (w_tmo_evt) begin
                        r_timeout  <= 1'b1;
                        r_have_ref <= 1'b0;
                        r_good_cnt <= '0;
                    end
                end

                ST_HIGH: begin
                    if (w_fall) begin
                        r_index_stb <= 1'b1;
                        r_timeout   <= 1'b0;
                        r_have_ref  <= 1'b1;
                        r_state     <= ST_LOW;
                        if (r_have_ref) begin
                            r_period     <= r_period_cnt;
                            r_period_stb <= 1'b1;
                            r_period_err <= !w_period_ok;
                            if (!w_period_ok) begin
                                r_good_cnt <= '0;
                            end else if (r_width_ok && (r_good_cnt != c_lock)) begin
                                r_good_cnt <= r_good_cnt + 1'b1;
                            end
                        end
                    end else if (w_tmo_evt) begin
                        r_timeout  <= 1'b1;
                        r_have_ref <= 1'b0;
                        r_good_cnt <= '0;
                        r_state    <= ST_ARMED;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase

            // Lock follows the good-revolution count one cycle later, but
            // drops immediately when the index disappears.
            if (w_tmo_evt) begin
                r_locked <= 1'b0;
                r_led    <= 1'b1;
            end else begin
                r_locked <= (r_good_cnt == c_lock);
                r_led    <= (r_good_cnt != c_lock);
            end
        end
    end

    assign index_stb  = r_index_stb;
    assign width_stb  = r_width_stb;
    assign period_stb = r_period_stb;
    assign width      = r_width;
    assign period     = r_period;
    assign width_err  = r_width_err;
    assign period_err = r_period_err;
    assign locked     = r_locked;
    assign timeout    = r_timeout;
    assign led        = r_led;

endmodule : mfm_index_monitor
`default_nettype wire

// File: tb/tb_mfm_index_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mfm_index_monitor
//  Description : Scoreboard bench for mfm_index_monitor with scaled timing
//                parameters (pulse 50..200, period 800..870, lock after 3).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mfm_index_monitor;

    localparam int PMIN   = 50;
    localparam int PMAX   = 200;
    localparam int PERMIN = 800;
    localparam int PERMAX = 870;
    localparam int LOCK   = 3;
    localparam int W      = 24;

    logic         clk50 = 1'b0;
    logic         reset = 1'b1;
    logic         index_l_in = 1'b1;
    logic         index_stb, width_stb, period_stb;
    logic [W-1:0] width, period;
    logic         width_err, period_err, locked, timeout, led;

    mfm_index_monitor #(
        .PULSE_MIN  (PMIN),
        .PULSE_MAX  (PMAX),
        .PERIOD_MIN (PERMIN),
        .PERIOD_MAX (PERMAX),
        .LOCK_COUNT (LOCK),
        .CNT_W      (W)
    ) dut (
        .clk50      (clk50),
        .reset      (reset),
        .index_l_in (index_l_in),
        .index_stb  (index_stb),
        .width_stb  (width_stb),
        .period_stb (period_stb),
        .width      (width),
        .period     (period),
        .width_err  (width_err),
        .period_err (period_err),
        .locked     (locked),
        .timeout    (timeout),
        .led        (led)
    );

    always #10 clk50 = ~clk50;

    int cyc = 0;
    always @(posedge clk50) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int cyc;
        int val;
        bit stb;
        bit err;
    } ev_t;

    ev_t q_idx[$];
    ev_t q_wid[$];
    int  q_werr[$];
    int  q_tmo[$];

    // ---------------- monitor ----------------
    logic tmo_q = 1'b0;
    ev_t  e;
    int   c;

    always @(negedge clk50) begin
        if (index_stb) begin
            if (q_idx.size() == 0) check("idx_unexpected", 1, 0);
            else begin
                e = q_idx.pop_front();
                check("idx_cycle", cyc, e.cyc);
                check("idx_pstb", period_stb, e.stb);
                if (e.stb) check("period_val", period, e.val);
                check("period_err", period_err, e.err);
            end
        end else if (period_stb || period_err) begin
            check("pstb_without_idx", 1, 0);
        end
        if (width_stb) begin
            if (q_wid.size() == 0) check("wid_unexpected", 1, 0);
            else begin
                e = q_wid.pop_front();
                check("wid_cycle", cyc, e.cyc);
                check("width_val", width, e.val);
                check("width_err", width_err, e.err);
            end
        end else if (width_err) begin
            if (q_werr.size() == 0) check("stuck_unexpected", 1, 0);
            else begin
                c = q_werr.pop_front();
                check("stuck_cycle", cyc, c);
            end
        end
        if (timeout && !tmo_q) begin
            if (q_tmo.size() == 0) check("tmo_unexpected", 1, 0);
            else begin
                c = q_tmo.pop_front();
                check("tmo_cycle", cyc, c);
            end
        end
        tmo_q <= timeout;
    end

    // ---------------- stimulus ----------------
    int last_fall = 0;

    task automatic do_fall(input bit ps, input bit pe);
        @(posedge clk50); #1;
        index_l_in = 1'b0;
        q_idx.push_back('{cyc + 3, cyc - last_fall, ps, pe});
        last_fall = cyc;
    endtask

    task automatic do_rise(input bit we);
        @(posedge clk50); #1;
        index_l_in = 1'b1;
        q_wid.push_back('{cyc + 3, cyc - last_fall, 1'b1, we});
    endtask

    // One revolution: fall, low phase, rise, high phase. pre/post are the
    // expected lock levels on the strobe cycle and the one after (-1: skip).
    task automatic rev(input int low, input int high, input bit ps, input bit pe,
                       input bit we, input bit st, input bit tm,
                       input int pre, input int post);
        do_fall(ps, pe);
        if (st) q_werr.push_back(last_fall + 3 + PMAX + 1);
        if (tm) q_tmo.push_back(last_fall + 3 + PERMAX + 1);
        if (pre >= 0) begin
            repeat (3) @(posedge clk50);
            @(negedge clk50);
            check("locked_at_stb", locked, pre);
            @(posedge clk50);
            @(negedge clk50);
            check("locked_after", locked, post);
            check("led_after", led, (post == 0) ? 1 : 0);
            check("timeout_cleared", timeout, 0);
            repeat (low - 5) @(posedge clk50);
        end else begin
            repeat (low - 1) @(posedge clk50);
        end
        do_rise(we);
        repeat (high - 1) @(posedge clk50);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_width"}, width, 0);
        check({tag, "_period"}, period, 0);
        check({tag, "_strobes"}, {index_stb, width_stb, period_stb, width_err, period_err}, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_led"}, led, 1);
    endtask

    initial begin
        repeat (5) @(posedge clk50);
        @(negedge clk50);
        check_reset_vals("rst");
        @(posedge clk50); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk50);

        // nominal rotation, lock after the 4th index
        rev(100, 733, 0, 0, 0, 0, 0, -1, -1);
        rev(100, 733, 1, 0, 0, 0, 0,  0,  0);
        rev(100, 733, 1, 0, 0, 0, 0,  0,  0);
        rev(100, 733, 1, 0, 0, 0, 0,  0,  1);
        rev(100, 733, 1, 0, 0, 0, 0,  1,  1);
        // short pulse while locked, then relock
        rev( 20, 813, 1, 0, 1, 0, 0,  1,  1);
        rev(100, 733, 1, 0, 0, 0, 0,  0,  0);
        rev(100, 733, 1, 0, 0, 0, 0,  0,  0);
        rev(100, 733, 1, 0, 0, 0, 0,  0,  0);
        rev(100, 733, 1, 0, 0, 0, 0,  0,  1);
        // period boundaries: 800 and 870 legal, 799 illegal
        rev(100, 700, 1, 0, 0, 0, 0,  1,  1);
        rev(100, 770, 1, 0, 0, 0, 0,  1,  1);
        rev(100, 699, 1, 0, 0, 0, 0,  1,  1);
        // slow spindle: 900-cycle period times out in HIGH
        rev(100, 800, 1, 1, 0, 0, 1,  1,  0);
        rev(100, 733, 0, 0, 0, 0, 0,  0,  0);
        // stuck low (timeout in HIGH), then stuck past timeout in LOW
        rev(500, 500, 1, 0, 1, 1, 1,  0,  0);
        rev(900, 100, 0, 0, 1, 1, 1,  0,  0);
        rev(100, 733, 0, 0, 0, 0, 0,  0,  0);

        // reset in the middle of a low pulse, released while still low
        do_fall(1, 0);
        repeat (49) @(posedge clk50); #1;
        reset = 1'b1;
        repeat (4) @(posedge clk50);
        @(negedge clk50);
        check_reset_vals("midrst");
        @(posedge clk50); #1;
        reset = 1'b0;
        repeat (100) @(posedge clk50);
        @(negedge clk50);
        check_reset_vals("post_rst_low");
        @(posedge clk50); #1;
        index_l_in = 1'b1;
        repeat (299) @(posedge clk50);
        rev(100, 733, 0, 0, 0, 0, 0,  0,  0);
        rev(100, 733, 1, 0, 0, 0, 0,  0,  0);

        repeat (10) @(posedge clk50);
        @(negedge clk50);
        check("q_idx_left", q_idx.size(), 0);
        check("q_wid_left", q_wid.size(), 0);
        check("q_werr_left", q_werr.size(), 0);
        check("q_tmo_left", q_tmo.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mfm_index_monitor
`default_nettype wire
